rv32_multicycle_control: RTL and testbench
==========================================

Name: rv32_multicycle_control

Overview:
- Multi-cycle successor to the single-cycle RV32 control unit. Replaces the per-instruction combinational decode with a sequencing FSM that issues one datapath step per clock.
- Adds a memory ready/wait handshake, full RV32I branch resolution from NZVC flags, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register and the shared-memory multi-cycle datapath.

Parameters:
- ALU_CTRL_W, 4, width of alu_control; must be >= 4.
- CNT_W, 32, width of the instret counter.
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- alu_flags  in  4  {C,V,N,Z} = bits [3:0] as {3,2,1,0}, taken from the ALU result of the current cycle.
- mem_ready  in  1  memory has completed the current read or write.
- mem_req  out  1  memory access request.
- mem_write  out  1  1 = write access, valid only with mem_req.
- adr_src  out  1  0 = PC, 1 = ALUOut.
- ir_write  out  1  latch IR and OldPC.
- pc_write  out  1  load PC from the result bus.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  2  0 = PC, 1 = OldPC, 2 = rs1, 3 = zero.
- alu_src_b  out  2  0 = rs2, 1 = imm, 2 = constant 4.
- imm_src  out  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U.
- result_src  out  2  0 = ALUOut, 1 = mem data, 2 = ALU result.
- alu_control  out  ALU_CTRL_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
- illegal  out  1  sticky trap flag.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: the synchronous reset loads state = FETCH, illegal = 0 and instret = 0.
  - While reset is high, all strobes (mem_req, mem_write, ir_write, pc_write, reg_write) are forced to 0.
  - Select outputs hold their FETCH values.
  - Reset mid-access abandons the access with no write.
- Strobe decoding:
  - All strobes are decoded from the state, except pc_write in BRANCH.
  - Every memory-state strobe is qualified by mem_ready.
- FETCH:
  - Outputs: mem_req = 1, adr_src = 0.
  - Stays in FETCH until mem_ready. On the mem_ready cycle: ir_write = 1, pc_write = 1, alu_src_a = 0, alu_src_b = 2, ADD, result_src = 2.
  - Next state: DECODE.
- DECODE:
  - Computes OldPC + imm (B) into ALUOut.
  - Dispatches on opcode:
    - 0000011 → MEMADR
    - 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - anything else → TRAP
- MEMADR: rs1 + imm (I for loads, S for stores). Next state MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req = 1, adr_src = 1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write = 1, result_src = 1. Next state FETCH; the instruction retires.
- MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1. Waits for mem_ready, then retires and goes to FETCH.
- EXECR: alu_control from funct3 and funct7_5:
  - 000 → ADD, or SUB if funct7_5 = 1
  - 001 → SLL
  - 010 → SLT
  - 011 → SLTU
  - 100 → XOR
  - 101 → SRL, or SRA if funct7_5 = 1
  - 110 → OR
  - 111 → AND
  - Next state: ALUWB.
- EXECI: same mapping as EXECR, except SUB is never selected. For funct3 = 101, funct7_5 selects SRA. Next state: ALUWB.
- ALUWB: reg_write = 1, result_src = 0. Retires and goes to FETCH.
- BRANCH:
  - ALU performs rs1 − rs2 (SUB). C = 1 means no borrow.
  - Taken condition by funct3:
    - 000: Z
    - 001: !Z
    - 100: N^V
    - 101: !(N^V)
    - 110: !C
    - 111: C
  - funct3 = 010 or 011 → TRAP with no retire.
  - When taken: pc_write = 1, result_src = 0 (ALUOut holds the target).
  - Retires, then goes to FETCH.
- JAL:
  - Cycle 1: rd ← OldPC + 4 (reg_write = 1, alu_src_a = 1, alu_src_b = 2, result_src = 2).
  - Then a second state: PC ← OldPC + imm J (pc_write = 1).
  - Retires and goes to FETCH.
- JALR: same as JAL, except the target is rs1 + imm I.
- LUI: rd ← 0 + imm U. Retires.
- AUIPC: rd ← OldPC + imm U. Retires.
- TRAP:
  - Sets illegal = 1 and stays in TRAP until reset.
  - No strobes asserted; instret frozen.
- instret:
  - Increments by 1 on each retire edge.
  - Wraps from 2^CNT_W − 1 to 0.
- MEM_HANDSHAKE = 0: every memory state lasts exactly one cycle.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready = 1 always → state sequence FETCH, DECODE, EXECR, ALUWB; reg_write = 1 only in cycle 4; alu_control = 0 in EXECR; instret 0 → 1.
- LW with mem_ready held low 3 cycles in both FETCH and MEMREAD → mem_req stays high; ir_write and reg_write each pulse exactly once; total 5 + 6 = 11 cycles; instret = 1.
- BLT with alu_flags {C,V,N,Z} = 0010 → pc_write = 1 in BRANCH; with flags 0110 → pc_write = 0; BGEU with C = 1 → taken.
- Opcode 0x00000000 → TRAP; illegal = 1 stays asserted for 20 cycles; no strobes; reset → FETCH, illegal = 0, instret = 0.
- Reset asserted during a MEMWRITE wait → mem_write never accompanied by mem_ready; next cycle state is FETCH with mem_req = 1.
- CNT_W = 4, 16 retired ALU instructions → instret wraps 15 → 0.

Source files
------------

// File: rtl/rv32_multicycle_control.sv
// rv32_multicycle_control
// Sequencing control unit for a shared-memory multi-cycle RV32I datapath.
// Each clock issues one datapath step. The unit handles the memory
// ready/wait handshake, resolves branches from the ALU NZVC flags, traps
// on illegal opcodes, and counts retired instructions.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode/funct3/      instruction fields taken from the instruction register
//   funct7_5
//   alu_flags           {C,V,N,Z} from the ALU result of the current cycle
//   mem_ready           memory has completed the current access
//   mem_req/mem_write   memory access request and write qualifier
//   adr_src             address select (0 = PC, 1 = ALUOut)
//   ir_write/pc_write/  datapath write strobes
//   reg_write
//   alu_src_a/b,        datapath operand, immediate and result selects
//   imm_src, result_src
//   alu_control         ALU operation code
//   illegal             sticky trap flag
//   instret             retired-instruction counter (wraps)
module rv32_multicycle_control #(
  parameter int ALU_CTRL_W    = 4,
  parameter int CNT_W         = 32,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic [3:0]            alu_flags,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            imm_src,
  output logic [1:0]            result_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal,
  output logic [CNT_W-1:0]      instret
);

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL1, S_JAL2,
    S_JALR1, S_JALR2, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  state_t            state_r;
  state_t            state_next_s;
  logic              illegal_r;
  logic [CNT_W-1:0]  instret_r;
  logic              ready_s;
  logic              br_legal_s;
  logic              retire_s;
  logic [3:0]        alu_code_s;

  // funct3/funct7_5 to ALU op; allow_sub is 0 for immediate forms, where
  // bit 30 is part of the immediate except on shifts.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7_5,
                                            input logic       allow_sub);
    case (f3)
      3'b000:  return (allow_sub && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  return 4'd7;
      3'b010:  return 4'd5;
      3'b011:  return 4'd6;
      3'b100:  return 4'd4;
      3'b101:  return f7_5 ? 4'd9 : 4'd8;
      3'b110:  return 4'd3;
      3'b111:  return 4'd2;
      default: return ALU_ADD;
    endcase
  endfunction

  // Branch condition from the flags of rs1 - rs2; C = 1 means no borrow.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic [3:0] flags);
    logic c, v, n, z;
    {c, v, n, z} = flags;
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n ^ v;
      3'b101:  return !(n ^ v);
      3'b110:  return !c;
      3'b111:  return c;
      default: return 1'b0;
    endcase
  endfunction

  assign ready_s    = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign br_legal_s = (funct3[2:1] != 2'b01);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_FETCH;
    else       state_r <= state_next_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FETCH:    state_next_s = ready_s ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
          OP_R:              state_next_s = S_EXECR;
          OP_I:              state_next_s = S_EXECI;
          OP_BRANCH:         state_next_s = S_BRANCH;
          OP_JAL:            state_next_s = S_JAL1;
          OP_JALR:           state_next_s = S_JALR1;
          OP_LUI:            state_next_s = S_LUI;
          OP_AUIPC:          state_next_s = S_AUIPC;
          default:           state_next_s = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next_s = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next_s = ready_s ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next_s = S_FETCH;
      S_MEMWRITE: state_next_s = ready_s ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_next_s = S_ALUWB;
      S_EXECI:    state_next_s = S_ALUWB;
      S_ALUWB:    state_next_s = S_FETCH;
      S_BRANCH:   state_next_s = br_legal_s ? S_FETCH : S_TRAP;
      S_JAL1:     state_next_s = S_JAL2;
      S_JALR1:    state_next_s = S_JALR2;
      S_JAL2:     state_next_s = S_FETCH;
      S_JALR2:    state_next_s = S_FETCH;
      S_LUI:      state_next_s = S_FETCH;
      S_AUIPC:    state_next_s = S_FETCH;
      S_TRAP:     state_next_s = S_TRAP;
      default:    state_next_s = S_FETCH;
    endcase
  end

  // Output decode; defaults are the FETCH selects, which also hold in reset
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd2;
    imm_src    = 3'd0;
    result_src = 2'd2;
    alu_code_s = ALU_ADD;
    retire_s   = 1'b0;
    if (reset) begin
      retire_s = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = ready_s;
          pc_write = ready_s;
        end
        S_DECODE: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd1;
          imm_src   = 3'd2;
        end
        S_MEMADR: begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          imm_src   = (opcode == OP_STORE) ? 3'd1 : 3'd0;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = 2'd1;
          retire_s   = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          retire_s  = ready_s;
        end
        S_EXECR: begin
          alu_src_a  = 2'd2;
          alu_src_b  = 2'd0;
          alu_code_s = alu_decode(funct3, funct7_5, 1'b1);
        end
        S_EXECI: begin
          alu_src_a  = 2'd2;
          alu_src_b  = 2'd1;
          alu_code_s = alu_decode(funct3, funct7_5, 1'b0);
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          result_src = 2'd0;
          retire_s   = 1'b1;
        end
        S_BRANCH: begin
          // ALUOut already holds the target computed in DECODE
          alu_src_a  = 2'd2;
          alu_src_b  = 2'd0;
          alu_code_s = ALU_SUB;
          result_src = 2'd0;
          pc_write   = br_legal_s && branch_taken(funct3, alu_flags);
          retire_s   = br_legal_s;
        end
        S_JAL1, S_JALR1: begin
          reg_write = 1'b1;
          alu_src_a = 2'd1;
        end
        S_JAL2: begin
          pc_write  = 1'b1;
          alu_src_a = 2'd1;
          alu_src_b = 2'd1;
          imm_src   = 3'd3;
          retire_s  = 1'b1;
        end
        S_JALR2: begin
          pc_write  = 1'b1;
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          retire_s  = 1'b1;
        end
        S_LUI: begin
          reg_write = 1'b1;
          alu_src_a = 2'd3;
          alu_src_b = 2'd1;
          imm_src   = 3'd4;
          retire_s  = 1'b1;
        end
        S_AUIPC: begin
          reg_write = 1'b1;
          alu_src_a = 2'd1;
          alu_src_b = 2'd1;
          imm_src   = 3'd4;
          retire_s  = 1'b1;
        end
        S_TRAP:  retire_s = 1'b0;
        default: retire_s = 1'b0;
      endcase
    end
  end

  assign alu_control = ALU_CTRL_W'(alu_code_s);

  // Sticky trap flag, raised as the FSM enters TRAP
  always_ff @(posedge clk) begin
    if (reset)                       illegal_r <= 1'b0;
    else if (state_next_s == S_TRAP) illegal_r <= 1'b1;
    else                             illegal_r <= illegal_r;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)         instret_r <= '0;
    else if (retire_s) instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    else               instret_r <= instret_r;
  end

  assign illegal = illegal_r;
  assign instret = instret_r;

endmodule

// File: tb/tb_rv32_multicycle_control.sv
// Testbench for rv32_multicycle_control. A per-instruction reference model
// builds the expected strobe sequence from instruction class, memory wait
// counts and branch operands; random instruction streams are checked cycle
// by cycle. A second instance (CNT_W = 4, no handshake) checks counter wrap.
module tb_rv32_multicycle_control;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7_5 = 1'b0;
  logic [3:0] alu_flags = 4'd0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic [31:0] instret;

  logic reset2 = 1'b1;
  logic [6:0] opcode2 = 7'd0;
  logic [2:0] funct3_2 = 3'd0;
  logic mem_ready2 = 1'b0;
  logic mem_req2, mem_write2, adr_src2, ir_write2, pc_write2, reg_write2, illegal2;
  logic [1:0] alu_src_a2, alu_src_b2, result_src2;
  logic [2:0] imm_src2;
  logic [3:0] alu_control2;
  logic [3:0] instret2;

  rv32_multicycle_control #(.ALU_CTRL_W(4), .CNT_W(32), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .alu_flags(alu_flags), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .result_src(result_src),
    .alu_control(alu_control), .illegal(illegal), .instret(instret)
  );

  rv32_multicycle_control #(.ALU_CTRL_W(4), .CNT_W(4), .MEM_HANDSHAKE(1'b0)) dut2 (
    .clk(clk), .reset(reset2), .opcode(opcode2), .funct3(funct3_2), .funct7_5(1'b0),
    .alu_flags(4'd0), .mem_ready(mem_ready2), .mem_req(mem_req2), .mem_write(mem_write2),
    .adr_src(adr_src2), .ir_write(ir_write2), .pc_write(pc_write2), .reg_write(reg_write2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .imm_src(imm_src2), .result_src(result_src2),
    .alu_control(alu_control2), .illegal(illegal2), .instret(instret2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned model_instret = 0;

  // strb = {mem_req, mem_write, adr_src (masked by mem_req), ir_write, pc_write, reg_write}
  typedef struct packed {
    logic [5:0] strb;
    logic       ready;
    logic       chk_alu;
    logic [3:0] alu;
    logic       chk_rs;
    logic [1:0] rs;
    logic       ill;
  } step_t;

  step_t exp_q[$];

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic step_t mk(input logic [5:0] strb, input logic chk_alu, input logic [3:0] alu,
                               input logic chk_rs, input logic [1:0] rs, input logic ill,
                               input logic ready);
    step_t s;
    s.strb = strb; s.chk_alu = chk_alu; s.alu = alu;
    s.chk_rs = chk_rs; s.rs = rs; s.ill = ill; s.ready = ready;
    return s;
  endfunction

  // ALU operation table for register/immediate arithmetic
  function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd7;
      3'd2:    return 4'd5;
      3'd3:    return 4'd6;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd9 : 4'd8;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Reference model: expected cycle-by-cycle behaviour of one instruction
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic taken, input int fw, input int mw, output logic retires);
    exp_q.delete();
    retires = 1'b1;
    for (int i = 0; i < fw; i++) exp_q.push_back(mk(6'b100000, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(6'b100110, 1'b1, 4'd0, 1'b1, 2'd2, 1'b0, 1'b1));
    exp_q.push_back(mk(6'b000000, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, rnd_bit()));
    case (op)
      OP_LOAD: begin
        exp_q.push_back(mk(6'b000000, 1'b1, 4'd0, 1'b0, 2'd0, 1'b0, rnd_bit()));
        for (int i = 0; i < mw; i++) exp_q.push_back(mk(6'b101000, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        exp_q.push_back(mk(6'b101000, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1));
        exp_q.push_back(mk(6'b000001, 1'b0, 4'd0, 1'b1, 2'd1, 1'b0, rnd_bit()));
      end
      OP_STORE: begin
        exp_q.push_back(mk(6'b000000, 1'b1, 4'd0, 1'b0, 2'd0, 1'b0, rnd_bit()));
        for (int i = 0; i < mw; i++) exp_q.push_back(mk(6'b111000, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        exp_q.push_back(mk(6'b111000, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1));
      end
      OP_R, OP_I: begin
        exp_q.push_back(mk(6'b000000, 1'b1, exp_alu(f3, f7, op == OP_R), 1'b0, 2'd0, 1'b0, rnd_bit()));
        exp_q.push_back(mk(6'b000001, 1'b0, 4'd0, 1'b1, 2'd0, 1'b0, rnd_bit()));
      end
      OP_BRANCH: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          exp_q.push_back(mk(6'b000000, 1'b1, 4'd1, 1'b0, 2'd0, 1'b0, rnd_bit()));
          for (int i = 0; i < 5; i++) exp_q.push_back(mk(6'b000000, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1, rnd_bit()));
          retires = 1'b0;
        end else begin
          exp_q.push_back(mk({4'b0000, taken, 1'b0}, 1'b1, 4'd1, taken, 2'd0, 1'b0, rnd_bit()));
        end
      end
      OP_JAL, OP_JALR: begin
        exp_q.push_back(mk(6'b000001, 1'b1, 4'd0, 1'b1, 2'd2, 1'b0, rnd_bit()));
        exp_q.push_back(mk(6'b000010, 1'b1, 4'd0, 1'b0, 2'd0, 1'b0, rnd_bit()));
      end
      OP_LUI, OP_AUIPC: begin
        exp_q.push_back(mk(6'b000001, 1'b1, 4'd0, 1'b1, 2'd2, 1'b0, rnd_bit()));
      end
      default: begin
        for (int i = 0; i < 20; i++) exp_q.push_back(mk(6'b000000, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1, rnd_bit()));
        retires = 1'b0;
      end
    endcase
  endtask

  // Drive one instruction from FETCH and compare every cycle against the model
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [3:0] flags, input logic taken, input int fw, input int mw,
                           input string name);
    logic retires;
    logic [5:0] obs;
    step_t e;
    build(op, f3, f7, taken, fw, mw, retires);
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      opcode = op; funct3 = f3; funct7_5 = f7; alu_flags = flags; mem_ready = e.ready;
      @(negedge clk);
      obs = {mem_req, mem_write, mem_req & adr_src, ir_write, pc_write, reg_write};
      n_cmp++;
      if (obs !== e.strb) begin
        n_bad++;
        $display("FAIL %s step %0d strobes got %b want %b", name, i, obs, e.strb);
      end
      n_cmp++;
      if (illegal !== e.ill) begin
        n_bad++;
        $display("FAIL %s step %0d illegal got %b want %b", name, i, illegal, e.ill);
      end
      if (e.chk_alu) begin
        n_cmp++;
        if (alu_control !== e.alu) begin
          n_bad++;
          $display("FAIL %s step %0d alu_control got %0d want %0d", name, i, alu_control, e.alu);
        end
      end
      if (e.chk_rs) begin
        n_cmp++;
        if (result_src !== e.rs) begin
          n_bad++;
          $display("FAIL %s step %0d result_src got %0d want %0d", name, i, result_src, e.rs);
        end
      end
      @(posedge clk); #1;
    end
    if (retires) model_instret++;
    n_cmp++;
    if (instret !== model_instret) begin
      n_bad++;
      $display("FAIL %s instret got %0d want %0d", name, instret, model_instret);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_instret = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = OP_STORE;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_req, mem_write, ir_write, pc_write, reg_write} !== 5'b00000) begin
        n_bad++;
        $display("FAIL reset_strobes got %b want 00000", {mem_req, mem_write, ir_write, pc_write, reg_write});
      end
      n_cmp++;
      if ({adr_src, alu_src_a, alu_src_b, alu_control, result_src} !== {1'b0, 2'd0, 2'd2, 4'd0, 2'd2}) begin
        n_bad++;
        $display("FAIL reset_selects got %b want %b", {adr_src, alu_src_a, alu_src_b, alu_control, result_src},
                 {1'b0, 2'd0, 2'd2, 4'd0, 2'd2});
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    model_instret = 0;
    n_cmp++;
    if (illegal !== 1'b0 || instret !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_regs got illegal=%b instret=%0d want 0/0", illegal, instret);
    end
  endtask

  task automatic test_add();
    run_instr(OP_R, 3'd0, 1'b0, 4'd0, 1'b0, 0, 0, "add");
  endtask

  task automatic test_lw_wait();
    run_instr(OP_LOAD, 3'd2, 1'b0, 4'd0, 1'b0, 3, 3, "lw_wait");
  endtask

  task automatic test_branch();
    run_instr(OP_BRANCH, 3'd4, 1'b0, 4'b0010, 1'b1, 0, 0, "blt_taken");
    run_instr(OP_BRANCH, 3'd4, 1'b0, 4'b0110, 1'b0, 0, 0, "blt_not_taken");
    run_instr(OP_BRANCH, 3'd7, 1'b0, 4'b1000, 1'b1, 1, 0, "bgeu_taken");
  endtask

  // Random instruction stream; branch flags come from real operand pairs
  task automatic test_random();
    logic [6:0] ops [9] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    logic [2:0] bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      logic [31:0] a, b, d;
      logic c, v, nn, z, tk;
      op = ops[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      d = a - b;
      z = (d == 32'd0); nn = d[31]; c = (a >= b);
      v = (a[31] != b[31]) && (d[31] != a[31]);
      tk = 1'b0;
      if (op == OP_BRANCH) begin
        f3 = bf3[$urandom_range(0, 5)];
        case (f3)
          3'd0:    tk = (a == b);
          3'd1:    tk = (a != b);
          3'd4:    tk = ($signed(a) < $signed(b));
          3'd5:    tk = ($signed(a) >= $signed(b));
          3'd6:    tk = (a < b);
          default: tk = (a >= b);
        endcase
      end
      run_instr(op, f3, rnd_bit(), {c, v, nn, z}, tk, $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_trap();
    run_instr(7'd0, 3'd0, 1'b0, 4'd0, 1'b0, 0, 0, "trap");
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_write, ir_write, pc_write, reg_write} !== 5'b00000) begin
      n_bad++;
      $display("FAIL trap_reset_strobes got %b want 00000", {mem_req, mem_write, ir_write, pc_write, reg_write});
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0; model_instret = 0;
    n_cmp++;
    if (illegal !== 1'b0 || instret !== 32'd0) begin
      n_bad++;
      $display("FAIL trap_reset_regs got illegal=%b instret=%0d want 0/0", illegal, instret);
    end
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1 || adr_src !== 1'b0) begin
      n_bad++;
      $display("FAIL trap_reset_fetch got mem_req=%b adr_src=%b want 1/0", mem_req, adr_src);
    end
    @(posedge clk); #1;
    run_instr(OP_LUI, 3'd0, 1'b0, 4'd0, 1'b0, 0, 0, "after_trap");
  endtask

  task automatic test_illegal_branch();
    run_instr(OP_BRANCH, 3'd3, 1'b0, 4'b1111, 1'b0, 0, 0, "bad_branch");
    apply_reset();
  endtask

  task automatic test_reset_mid_write();
    opcode = OP_STORE; funct3 = 3'd2; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_req, mem_write, adr_src} !== 3'b111) begin
        n_bad++;
        $display("FAIL write_wait got %b want 111", {mem_req, mem_write, adr_src});
      end
      @(posedge clk); #1;
    end
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_write} !== 2'b00) begin
      n_bad++;
      $display("FAIL write_reset got %b want 00", {mem_req, mem_write});
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0; model_instret = 0;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_write, adr_src, illegal} !== 4'b1000 || instret !== 32'd0) begin
      n_bad++;
      $display("FAIL write_abandon got %b instret=%0d want 1000/0", {mem_req, mem_write, adr_src, illegal}, instret);
    end
    @(posedge clk); #1;
    run_instr(OP_R, 3'd5, 1'b1, 4'd0, 1'b0, 0, 0, "after_abandon");
  endtask

  // Second instance: single-cycle memory states and 4-bit counter wrap
  task automatic test_wrap_no_handshake();
    int cnt;
    int ncyc;
    logic [3:0] e;
    cnt = 0;
    mem_ready2 = 1'b0;
    reset2 = 1'b1;
    @(posedge clk); #1;
    reset2 = 1'b0;
    for (int k = 0; k < 18; k++) begin
      opcode2 = (k == 0) ? OP_LOAD : ((k == 17) ? OP_STORE : OP_R);
      funct3_2 = 3'($urandom_range(0, 7));
      ncyc = (k == 0) ? 5 : 4;
      for (int c = 0; c < ncyc; c++) begin
        @(negedge clk);
        if (c == 0) begin
          n_cmp++;
          if ({mem_req2, ir_write2} !== 2'b11) begin
            n_bad++;
            $display("FAIL nohs_fetch k=%0d got %b want 11", k, {mem_req2, ir_write2});
          end
        end
        if (c == ncyc - 1) begin
          n_cmp++;
          if ({mem_write2, reg_write2} !== ((k == 17) ? 2'b10 : 2'b01)) begin
            n_bad++;
            $display("FAIL nohs_last k=%0d got %b want %b", k, {mem_write2, reg_write2},
                     (k == 17) ? 2'b10 : 2'b01);
          end
        end
        @(posedge clk); #1;
      end
      cnt++;
      e = 4'(cnt % 16);
      n_cmp++;
      if (instret2 !== e) begin
        n_bad++;
        $display("FAIL nohs_instret k=%0d got %0d want %0d", k, instret2, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_random();
    test_trap();
    test_illegal_branch();
    test_reset_mid_write();
    test_wrap_no_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
